// File: rtl/modn_counter_param.sv
// modn_counter_param: parametrised modulo-N up/down counter with
// enable, direction, synchronous load and a cascadable terminal count.
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-low reset
//   en       in  1      count enable
//   up_dn    in  1      1 = up, 0 = down
//   load     in  1      synchronous load strobe (beats en)
//   load_val in  WIDTH  value to load
//   count    out WIDTH  registered count
//   tc       out 1      combinational terminal-count carry
//   wrap     out 1      registered pulse after a wrap
//   load_err out 1      registered pulse after an illegal load
//
// Optional feature macro: MODN_PRESCALE_EN adds an enable prescaler
// of PRESCALE enabled cycles per count step.

module modn_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int INIT     = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
            $error("MODULUS out of range 2..2**WIDTH");
        end
        if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
            $error("INIT must be below MODULUS");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $error("PRESCALE must be at least 1");
        end
    endgenerate

    logic             w_en_eff;
    logic             w_at_end;
    logic             w_load_ok;
    logic             w_tc;
    logic [WIDTH-1:0] w_step;

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_err;

`ifdef MODN_PRESCALE_EN
    // One bit minimum so PRESCALE=1 still elaborates; the
    // prescaler then sits at 0 and every enabled cycle ticks.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (load) begin
            r_pre <= '0;
        end else if (en) begin
            if (r_pre == P_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign w_en_eff = en & (r_pre == P_LAST);
`else
    assign w_en_eff = en;
`endif

    // Terminal value depends on direction: top when up, zero when down.
    assign w_at_end  = up_dn ? (r_count == LAST) : (r_count == '0);
    assign w_load_ok = {1'b0, load_val} < MOD_EXT;
    assign w_tc      = w_en_eff & ~load & w_at_end;

    always_comb begin
        w_step = r_count;
        if (up_dn) begin
            w_step = w_at_end ? '0 : r_count + 1'b1;
        end else begin
            w_step = w_at_end ? LAST : r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= INIT_V;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_ok ? load_val : '0;
            r_err   <= ~w_load_ok;
            r_wrap  <= 1'b0;
        end else if (w_en_eff) begin
            r_count <= w_step;
            r_err   <= 1'b0;
            // A step taken at the terminal value is exactly a wrap.
            r_wrap  <= w_at_end;
        end else begin
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign count    = r_count;
    assign tc       = w_tc;
    assign wrap     = r_wrap;
    assign load_err = r_err;

endmodule

// File: tb/tb_modn_counter_param.sv
// tb_modn_counter_param: directed bench for modn_counter_param with
// a modular-arithmetic reference model and per-cycle comparison.

module tb_modn_counter_param;

    localparam int PS = 3;
    localparam int MODS [2] = '{10, 16};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       cen = 1'b0;

    logic [3:0] cnt0, cnt1, ca_cnt, cb_cnt;
    logic       tc0, wr0, er0;
    logic       tc1, wr1, er1;
    logic       ca_tc, ca_wr, ca_er;
    logic       cb_tc, cb_wr, cb_er;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt [2] = '{0, 0};
    int m_wrap [2] = '{0, 0};
    int m_err [2] = '{0, 0};
`ifdef MODN_PRESCALE_EN
    int m_pre [2] = '{0, 0};
`endif
    int c_val = 0;

    modn_counter_param #(
        .WIDTH(4), .MODULUS(10), .INIT(0), .PRESCALE(PS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val),
        .count(cnt0), .tc(tc0), .wrap(wr0), .load_err(er0)
    );

    modn_counter_param #(
        .WIDTH(4), .MODULUS(16), .INIT(0), .PRESCALE(PS)
    ) d16 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val),
        .count(cnt1), .tc(tc1), .wrap(wr1), .load_err(er1)
    );

    modn_counter_param #(
        .WIDTH(4), .MODULUS(10), .INIT(0), .PRESCALE(1)
    ) ca (
        .clk(clk), .rst(rst), .en(cen), .up_dn(1'b1),
        .load(1'b0), .load_val(4'd0),
        .count(ca_cnt), .tc(ca_tc), .wrap(ca_wr), .load_err(ca_er)
    );

    modn_counter_param #(
        .WIDTH(4), .MODULUS(10), .INIT(0), .PRESCALE(1)
    ) cb (
        .clk(clk), .rst(rst), .en(ca_tc), .up_dn(1'b1),
        .load(1'b0), .load_val(4'd0),
        .count(cb_cnt), .tc(cb_tc), .wrap(cb_wr), .load_err(cb_er)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic bit m_tick(input int k);
`ifdef MODN_PRESCALE_EN
        return en && (m_pre[k] == PS - 1);
`else
        return en && (k >= 0);
`endif
    endfunction

    function automatic bit exp_tc(input int k);
        bit at_end;
        at_end = up_dn ? (m_cnt[k] == MODS[k] - 1) : (m_cnt[k] == 0);
        return m_tick(k) && !load && at_end;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0;
                m_wrap[k] = 0;
                m_err[k] = 0;
`ifdef MODN_PRESCALE_EN
                m_pre[k] = 0;
`endif
            end
            c_val = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit t;
                t = m_tick(k);
`ifdef MODN_PRESCALE_EN
                if (load) m_pre[k] = 0;
                else if (en) m_pre[k] = (m_pre[k] + 1) % PS;
`endif
                m_wrap[k] = 0;
                m_err[k] = 0;
                if (load) begin
                    if (int'(load_val) < MODS[k]) begin
                        m_cnt[k] = int'(load_val);
                    end else begin
                        m_cnt[k] = 0;
                        m_err[k] = 1;
                    end
                end else if (t) begin
                    if (up_dn) begin
                        m_wrap[k] = int'(m_cnt[k] == MODS[k] - 1);
                        m_cnt[k] = (m_cnt[k] + 1) % MODS[k];
                    end else begin
                        m_wrap[k] = int'(m_cnt[k] == 0);
                        m_cnt[k] = (m_cnt[k] + MODS[k] - 1) % MODS[k];
                    end
                end
            end
            if (cen) c_val = (c_val + 1) % 100;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cmp("cnt10", int'(cnt0), m_cnt[0]);
            cmp("wrap10", int'(wr0), m_wrap[0]);
            cmp("err10", int'(er0), m_err[0]);
            cmp("tc10", int'(tc0), int'(exp_tc(0)));
            cmp("cnt16", int'(cnt1), m_cnt[1]);
            cmp("wrap16", int'(wr1), m_wrap[1]);
            cmp("err16", int'(er1), m_err[1]);
            cmp("tc16", int'(tc1), int'(exp_tc(1)));
            cmp("casc_val", int'(ca_cnt) + 10 * int'(cb_cnt), c_val);
            cmp("casc_tc0", int'(ca_tc), int'(cen && (c_val % 10 == 9)));
            cmp("casc_tc1", int'(cb_tc), int'(cen && (c_val == 99)));
        end
    end

    initial begin
        #10;
        cmp("rst_cnt", int'(cnt0), 0);
        cmp("rst_wrap", int'(wr0), 0);
        cmp("rst_err", int'(er0), 0);
        #2;
        rst = 1'b1;
        en = 1'b1;
        up_dn = 1'b1;
`ifdef MODN_PRESCALE_EN
        begin
            int ps_c [6] = '{0, 0, 1, 1, 1, 2};
            cmp("ps_start", int'(cnt0), 0);
            for (int i = 0; i < 6; i++) begin
                cyc();
                cmp("ps_cnt", int'(cnt0), ps_c[i]);
            end
        end
`else
        for (int i = 1; i <= 10; i++) begin
            cyc();
            cmp("up_cnt", int'(cnt0), i % 10);
            cmp("up_tc", int'(tc0), int'(i == 9));
            cmp("up_wrap", int'(wr0), int'(i == 10));
        end
        cyc();
        cmp("up_after", int'(cnt0), 1);
        cmp("up_wrap_end", int'(wr0), 0);

        load = 1'b1;
        load_val = 4'd2;
        en = 1'b0;
        cyc();
        cmp("ld2_cnt", int'(cnt0), 2);
        load = 1'b0;
        en = 1'b1;
        up_dn = 1'b0;
        begin
            int dn_c [4] = '{1, 0, 9, 8};
            int dn_w [4] = '{0, 0, 1, 0};
            for (int i = 0; i < 4; i++) begin
                cyc();
                cmp("dn_cnt", int'(cnt0), dn_c[i]);
                cmp("dn_wrap", int'(wr0), dn_w[i]);
            end
        end

        load = 1'b1;
        load_val = 4'd12;
        up_dn = 1'b1;
        cyc();
        cmp("bad_cnt", int'(cnt0), 0);
        cmp("bad_err", int'(er0), 1);
        cmp("bad_wrap", int'(wr0), 0);
        cmp("m16_ld12", int'(cnt1), 12);
        cmp("m16_err", int'(er1), 0);
        load_val = 4'd5;
        cyc();
        cmp("prio_cnt", int'(cnt0), 5);
        cmp("prio_err", int'(er0), 0);
        load_val = 4'd9;
        cyc();
        cmp("ld9_cnt", int'(cnt0), 9);
        cmp("ld_tc_mask", int'(tc0), 0);
        load = 1'b0;
        #1;
        cmp("tc_at_9", int'(tc0), 1);
        cyc();
        cmp("wrap_cnt", int'(cnt0), 0);
        cmp("wrap_pulse", int'(wr0), 1);

        load = 1'b1;
        load_val = 4'd15;
        cyc();
        cmp("ld15_cnt10", int'(cnt0), 0);
        cmp("ld15_err10", int'(er0), 1);
        cmp("ld15_cnt16", int'(cnt1), 15);
        cmp("ld15_err16", int'(er1), 0);
        load = 1'b0;
        #1;
        cmp("tc16_top", int'(tc1), 1);
        cyc();
        cmp("m16_wrap_cnt", int'(cnt1), 0);
        cmp("m16_wrap", int'(wr1), 1);
        cmp("m10_cnt", int'(cnt0), 1);
        up_dn = 1'b0;
        cyc();
        cmp("m16_dn_cnt", int'(cnt1), 15);
        cmp("m16_dn_wrap", int'(wr1), 1);
        cmp("m10_dn_cnt", int'(cnt0), 0);
        cmp("m10_dn_wrap", int'(wr0), 0);

        up_dn = 1'b1;
        load = 1'b1;
        load_val = 4'd6;
        cyc();
        load = 1'b0;
        cyc();
        cmp("pre_rst_cnt", int'(cnt0), 7);
        #1 rst = 1'b0;
        #1 cmp("arst_cnt", int'(cnt0), 0);
        @(negedge clk);
        #1 rst = 1'b1;

        load = 1'b1;
        load_val = 4'd14;
        cyc();
        cmp("pre_rst_err", int'(er0), 1);
        #1 rst = 1'b0;
        #1 cmp("arst_err", int'(er0), 0);
        @(negedge clk);
        #1 rst = 1'b1;

        load_val = 4'd9;
        cyc();
        load = 1'b0;
        cyc();
        cmp("pre_rst_wrap", int'(wr0), 1);
        #1 rst = 1'b0;
        #1 cmp("arst_wrap", int'(wr0), 0);
        @(negedge clk);
        #1 rst = 1'b1;
`endif

        en = 1'b0;
        load = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        cen = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (i == 10) begin
                cmp("casc10_lo", int'(ca_cnt), 0);
                cmp("casc10_hi", int'(cb_cnt), 1);
            end
        end
        cmp("casc100_lo", int'(ca_cnt), 0);
        cmp("casc100_hi", int'(cb_cnt), 0);
        cen = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
